// File: rtl/io_stream_bridge_if.sv
// CPU I/O request handshake plus host-side TX/RX word streams of the io_stream_bridge.
// The master side is the CPU/host pair; the slave side is the bridge.
interface io_stream_bridge_if #(
  parameter int unsigned AW = 2
);
  logic          io_read;
  logic          io_write;
  logic [15:0]   io_wdata;
  logic [15:0]   io_rdata;
  logic          ioack;
  logic [15:0]   tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [15:0]   rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW:0]   tx_count;
  logic [AW:0]   rx_count;

  modport master (
    output io_read, io_write, io_wdata, tx_ready, rx_data, rx_valid,
    input  io_rdata, ioack, tx_data, tx_valid, rx_ready, tx_count, rx_count
  );

  modport slave (
    input  io_read, io_write, io_wdata, tx_ready, rx_data, rx_valid,
    output io_rdata, ioack, tx_data, tx_valid, rx_ready, tx_count, rx_count
  );
endinterface

// File: rtl/io_stream_bridge.sv
// Peripheral target for the CPU I/O handshake: CPU stores feed a TX FIFO drained by the host,
// host words fill an RX FIFO popped by CPU loads; ioack is withheld while the FIFO cannot serve.
module io_stream_bridge #(
  parameter int unsigned AW = 2
) (
  input logic             clock,
  input logic             reset,
  io_stream_bridge_if.slave bus
);
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_TX, WAIT_RX, ACK} state_t;

  state_t          state;
  logic [DW-1:0]   tx_mem [DEPTH];
  logic [DW-1:0]   rx_mem [DEPTH];
  logic [AW-1:0]   tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0]   tx_cnt, rx_cnt;
  logic [DW-1:0]   rdata;
  logic            ack;

  logic tx_full_c, rx_empty_c, tx_push_c, tx_pop_c, rx_push_c, rx_pop_c;

  // FIFO strobes; all gating uses pre-edge counts so a same-edge pop never frees space for a push.
  always_comb begin
    tx_full_c  = (tx_cnt == CW'(DEPTH));
    rx_empty_c = (rx_cnt == '0);
    tx_pop_c   = (tx_cnt != '0) && bus.tx_ready;
    rx_push_c  = (rx_cnt != CW'(DEPTH)) && bus.rx_valid;
    tx_push_c  = 1'b0;
    rx_pop_c   = 1'b0;
    case (state)
      IDLE: begin
        rx_pop_c  = bus.io_read && !rx_empty_c;
        tx_push_c = !bus.io_read && bus.io_write && !tx_full_c;
      end
      WAIT_TX: tx_push_c = bus.io_write && !tx_full_c;
      WAIT_RX: rx_pop_c  = bus.io_read && !rx_empty_c;
      default: ;
    endcase
  end

  // Request/acknowledge FSM with registered ioack and read data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.io_read) begin
            if (rx_pop_c) begin
              rdata <= rx_mem[rx_rd_ptr];
              ack   <= 1'b1;
              state <= ACK;
            end else begin
              state <= WAIT_RX;
            end
          end else if (bus.io_write) begin
            if (tx_push_c) begin
              ack   <= 1'b1;
              state <= ACK;
            end else begin
              state <= WAIT_TX;
            end
          end
        end
        WAIT_TX: begin
          if (!bus.io_write) begin
            state <= IDLE;
          end else if (tx_push_c) begin
            ack   <= 1'b1;
            state <= ACK;
          end
        end
        WAIT_RX: begin
          if (!bus.io_read) begin
            state <= IDLE;
          end else if (rx_pop_c) begin
            rdata <= rx_mem[rx_rd_ptr];
            ack   <= 1'b1;
            state <= ACK;
          end
        end
        default: begin
          if (!bus.io_read && !bus.io_write) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
    end else begin
      if (tx_push_c) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop_c)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      if (rx_push_c) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop_c)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push_c) - CW'(tx_pop_c);
      rx_cnt <= rx_cnt + CW'(rx_push_c) - CW'(rx_pop_c);
    end
  end

  // Storage carries no reset; only pointers and counts define validity.
  always_ff @(posedge clock) begin
    if (tx_push_c) tx_mem[tx_wr_ptr] <= bus.io_wdata;
    if (rx_push_c) rx_mem[rx_wr_ptr] <= bus.rx_data;
  end

  assign bus.io_rdata = rdata;
  assign bus.ioack    = ack;
  assign bus.tx_data  = tx_mem[tx_rd_ptr];
  assign bus.tx_valid = (tx_cnt != '0);
  assign bus.rx_ready = (rx_cnt != CW'(DEPTH));
  assign bus.tx_count = tx_cnt;
  assign bus.rx_count = rx_cnt;
endmodule

// File: tb/tb_io_stream_bridge.sv
// Bench for io_stream_bridge: directed vector table, hand-written stall/reset sequences,
// and random CPU/host traffic compared each cycle against a queue-based reference model.
module tb_io_stream_bridge;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  io_stream_bridge_if #(.AW(AW)) bus ();
  io_stream_bridge #(.AW(AW)) dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: FIFOs as queues, one flag for "acknowledge outstanding".
  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  logic        m_ack   = 1'b0;
  logic [15:0] m_rdata = '0;

  typedef struct {
    logic rd, wr; logic [15:0] wd; logic txr, rxv; logic [15:0] rxd;
    logic e_ack; logic [15:0] e_rdata; logic [2:0] e_txc, e_rxc; logic e_txv; logic [15:0] e_txd;
  } vec_t;
  vec_t vecs[15];

  task automatic model_edge();
    int tx_n = txq.size();
    int rx_n = rxq.size();
    if (!reset) begin
      txq.delete(); rxq.delete(); m_ack = 1'b0; m_rdata = '0;
      return;
    end
    if (m_ack) begin
      if (!bus.io_read && !bus.io_write) m_ack = 1'b0;
    end else if (bus.io_read) begin
      if (rx_n > 0) begin m_rdata = rxq.pop_front(); m_ack = 1'b1; end
    end else if (bus.io_write && tx_n < DEPTH) begin
      txq.push_back(bus.io_wdata); m_ack = 1'b1;
    end
    if (bus.tx_ready && tx_n > 0) void'(txq.pop_front());
    if (bus.rx_valid && rx_n < DEPTH) rxq.push_back(bus.rx_data);
  endtask

  task automatic compare_model();
    logic bad;
    bad = (bus.ioack !== m_ack) || (bus.io_rdata !== m_rdata) ||
          (32'(bus.tx_count) != 32'(txq.size())) || (32'(bus.rx_count) != 32'(rxq.size())) ||
          (bus.tx_valid !== (txq.size() > 0)) || (bus.rx_ready !== (rxq.size() < DEPTH)) ||
          (txq.size() > 0 && bus.tx_data !== txq[0]);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL model @%0t: ack %b/%b rdata %h/%h txc %0d/%0d rxc %0d/%0d txv %b rxr %b",
               $time, bus.ioack, m_ack, bus.io_rdata, m_rdata, bus.tx_count, txq.size(),
               bus.rx_count, rxq.size(), bus.tx_valid, bus.rx_ready);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_model();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ack(input logic val, input int budget, input string name);
    int n = 0;
    while (bus.ioack !== val && n < budget) begin tick(); n++; end
    chk(name, 32'(bus.ioack), 32'(val));
  endtask

  task automatic cpu_store(input logic [15:0] v);
    bus.io_write = 1'b1; bus.io_wdata = v;
    wait_ack(1'b1, 20, "store_ack");
    bus.io_write = 1'b0;
    wait_ack(1'b0, 20, "store_release");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0,1'b1,16'h1234,1'b0,1'b0,16'h0000, 1'b1,16'h0000,3'd1,3'd0,1'b1,16'h1234};
    vecs[1]  = '{1'b0,1'b1,16'h1234,1'b0,1'b0,16'h0000, 1'b1,16'h0000,3'd1,3'd0,1'b1,16'h1234};
    vecs[2]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0000,3'd1,3'd0,1'b1,16'h1234};
    vecs[3]  = '{1'b0,1'b0,16'h0000,1'b0,1'b1,16'hBEEF, 1'b0,16'h0000,3'd1,3'd1,1'b1,16'h1234};
    vecs[4]  = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'hBEEF,3'd1,3'd0,1'b1,16'h1234};
    vecs[5]  = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'hBEEF,3'd1,3'd0,1'b1,16'h1234};
    vecs[6]  = '{1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'hBEEF,3'd0,3'd0,1'b0,16'h0000};
    vecs[7]  = '{1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0011, 1'b0,16'hBEEF,3'd0,3'd1,1'b0,16'h0000};
    vecs[8]  = '{1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0022, 1'b0,16'hBEEF,3'd0,3'd2,1'b0,16'h0000};
    vecs[9]  = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0033, 1'b1,16'h0011,3'd0,3'd2,1'b0,16'h0000};
    vecs[10] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0011,3'd0,3'd2,1'b0,16'h0000};
    vecs[11] = '{1'b1,1'b1,16'hDEAD,1'b0,1'b0,16'h0000, 1'b1,16'h0022,3'd0,3'd1,1'b0,16'h0000};
    vecs[12] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0022,3'd0,3'd1,1'b0,16'h0000};
    vecs[13] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0033,3'd0,3'd0,1'b0,16'h0000};
    vecs[14] = '{1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0033,3'd0,3'd0,1'b0,16'h0000};

    bus.io_read = 1'b0; bus.io_write = 1'b0; bus.io_wdata = '0;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("reset_ioack", 32'(bus.ioack), 32'd0);
    chk("reset_rdata", 32'(bus.io_rdata), 32'd0);
    chk("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("reset_tx_count", 32'(bus.tx_count), 32'd0);
    chk("reset_rx_count", 32'(bus.rx_count), 32'd0);
    chk("reset_rx_ready", 32'(bus.rx_ready), 32'd1);

    // Directed store/load/simultaneous/priority vectors, one clock each.
    for (int i = 0; i < 15; i++) begin
      bus.io_read = vecs[i].rd; bus.io_write = vecs[i].wr; bus.io_wdata = vecs[i].wd;
      bus.tx_ready = vecs[i].txr; bus.rx_valid = vecs[i].rxv; bus.rx_data = vecs[i].rxd;
      tick();
      chk($sformatf("vec%0d_ack", i), 32'(bus.ioack), 32'(vecs[i].e_ack));
      chk($sformatf("vec%0d_rdata", i), 32'(bus.io_rdata), 32'(vecs[i].e_rdata));
      chk($sformatf("vec%0d_txc", i), 32'(bus.tx_count), 32'(vecs[i].e_txc));
      chk($sformatf("vec%0d_rxc", i), 32'(bus.rx_count), 32'(vecs[i].e_rxc));
      chk($sformatf("vec%0d_txv", i), 32'(bus.tx_valid), 32'(vecs[i].e_txv));
      if (vecs[i].e_txv) chk($sformatf("vec%0d_txd", i), 32'(bus.tx_data), 32'(vecs[i].e_txd));
    end

    // Load from empty RX: stall, then data arrives.
    bus.io_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("empty_load_stall", 32'(bus.ioack), 32'd0);
    end
    bus.rx_valid = 1'b1; bus.rx_data = 16'h00A5;
    tick();
    bus.rx_valid = 1'b0;
    chk("empty_load_push_edge_ack", 32'(bus.ioack), 32'd0);
    chk("empty_load_push_edge_rxc", 32'(bus.rx_count), 32'd1);
    tick();
    chk("empty_load_ack", 32'(bus.ioack), 32'd1);
    chk("empty_load_rdata", 32'(bus.io_rdata), 32'h00A5);
    chk("empty_load_rxc", 32'(bus.rx_count), 32'd0);
    bus.io_read = 1'b0;
    wait_ack(1'b0, 5, "empty_load_release");

    // Full TX: fifth store stalls until one host pop, then drains in order.
    for (int i = 1; i <= 4; i++) cpu_store(16'(i));
    chk("full_tx_count", 32'(bus.tx_count), 32'd4);
    chk("full_tx_head", 32'(bus.tx_data), 32'd1);
    bus.io_write = 1'b1; bus.io_wdata = 16'd5;
    tick(); tick(); tick();
    chk("full_stall_ack", 32'(bus.ioack), 32'd0);
    chk("full_stall_txc", 32'(bus.tx_count), 32'd4);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    chk("full_pop_edge_ack", 32'(bus.ioack), 32'd0);
    chk("full_pop_edge_txc", 32'(bus.tx_count), 32'd3);
    tick();
    chk("full_retry_ack", 32'(bus.ioack), 32'd1);
    chk("full_retry_txc", 32'(bus.tx_count), 32'd4);
    bus.io_write = 1'b0;
    wait_ack(1'b0, 5, "full_release");
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("drain_%0d", i), 32'(bus.tx_data), 32'(i));
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
    end
    chk("drain_empty", 32'(bus.tx_valid), 32'd0);

    // Reset while acknowledging a store.
    bus.rx_valid = 1'b1; bus.rx_data = 16'h7777;
    tick();
    bus.rx_valid = 1'b0;
    cpu_store(16'h0011);
    cpu_store(16'h0022);
    bus.io_write = 1'b1; bus.io_wdata = 16'h0033;
    wait_ack(1'b1, 10, "midop_ack");
    chk("midop_txc", 32'(bus.tx_count), 32'd3);
    reset = 1'b0;
    tick();
    reset = 1'b1; bus.io_write = 1'b0;
    chk("midop_rst_ack", 32'(bus.ioack), 32'd0);
    chk("midop_rst_txc", 32'(bus.tx_count), 32'd0);
    chk("midop_rst_rxc", 32'(bus.rx_count), 32'd0);
    chk("midop_rst_txv", 32'(bus.tx_valid), 32'd0);
    chk("midop_rst_rxr", 32'(bus.rx_ready), 32'd1);
    tick();

    // Random CPU and host traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.tx_ready = 1'($urandom_range(0, 1));
      bus.rx_valid = ($urandom_range(0, 2) == 0);
      bus.rx_data  = 16'($urandom);
      if (!bus.io_read && !bus.io_write) begin
        if (!bus.ioack && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 4))
            0, 1: bus.io_read = 1'b1;
            2, 3: bus.io_write = 1'b1;
            default: begin bus.io_read = 1'b1; bus.io_write = 1'b1; end
          endcase
          bus.io_wdata = 16'($urandom);
        end
      end else if (bus.ioack && $urandom_range(0, 1) == 0) begin
        bus.io_read = 1'b0; bus.io_write = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
